// File: rtl/tick_timer_ctrl_pkg.sv
// Shared types and constants for the countdown tick timer.
// Two prescaler divisors: one for real silicon, one short enough for simulation.
package tick_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_RUN   = 2'd1,
    TT_PAUSE = 2'd2,
    TT_DONE  = 2'd3
  } tt_state_t;

  localparam int unsigned DIV_1HZ = 100000000;
  localparam int unsigned DIV_SIM = 4;

  // True when the state keeps the prescaler parked at zero.
  function automatic logic tt_is_parked(input tt_state_t s);
    return (s == TT_IDLE) || (s == TT_DONE);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter with synchronous clear and count enable.
// tick flags the terminal count; clear beats enable.
module tick_prescaler #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned PRE_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/tick_timer_ctrl.sv
// Countdown timer: prescaler-derived one-cycle tick enables decrement a loaded count.
// Start/stop/clear commands with priority clear > start > stop; one-shot or periodic.
module tick_timer_ctrl
  import tick_timer_ctrl_pkg::*;
#(
  parameter int unsigned DIV   = DIV_1HZ,
  parameter int unsigned PRE_W = 27,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick_o,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             done_pulse,
  output logic             expired,
  output logic             load_err
);

  tt_state_t        state;
  logic [CNT_W-1:0] reload;
  logic             mode_periodic;

  logic pre_wrap;
  logic cmd_load;
  logic cmd_reject;
  logic cmd_resume;
  logic cmd_pause;
  logic last_tick;
  logic pre_en;
  logic pre_clr;

  // Command decode; a start in PAUSE is always a resume, never a reload.
  assign cmd_load   = !clear && start && (state != TT_PAUSE) && (load_val != '0);
  assign cmd_reject = !clear && start && (state != TT_PAUSE) && (load_val == '0);
  assign cmd_resume = !clear && start && (state == TT_PAUSE);
  assign cmd_pause  = !clear && !start && stop && (state == TT_RUN);

  assign tick_o    = (state == TT_RUN) && pre_wrap;
  assign last_tick = tick_o && (remaining == CNT_W'(1));

  // A pause on the wrap cycle still lets the counter roll to 0, so the
  // consumed tick is not seen a second time after resume.
  assign pre_en  = (state == TT_RUN) && (!cmd_pause || pre_wrap);
  assign pre_clr = clear || cmd_load || tt_is_parked(state);

  tick_prescaler #(
    .DIV   (DIV),
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (pre_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= TT_IDLE;
      remaining     <= '0;
      reload        <= '0;
      mode_periodic <= 1'b0;
      done_pulse    <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      load_err   <= cmd_reject;

      if (clear) begin
        state     <= TT_IDLE;
        remaining <= '0;
      end else if (cmd_load) begin
        state         <= TT_RUN;
        remaining     <= load_val;
        reload        <= load_val;
        mode_periodic <= periodic;
      end else begin
        case (state)
          TT_RUN: begin
            if (tick_o) begin
              if (remaining > CNT_W'(1)) begin
                remaining <= remaining - 1'b1;
              end else if (last_tick) begin
                done_pulse <= 1'b1;
                remaining  <= mode_periodic ? reload : '0;
              end
            end
            // An exhausted one-shot finishes even if a pause arrives with it.
            if (last_tick && !mode_periodic) begin
              state <= TT_DONE;
            end else if (cmd_pause) begin
              state <= TT_PAUSE;
            end
          end
          TT_PAUSE: begin
            if (cmd_resume) begin
              state <= TT_RUN;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

  assign busy    = (state == TT_RUN) || (state == TT_PAUSE);
  assign expired = (state == TT_DONE);

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl with DIV=4; expectations are hand-derived.
module tb_tick_timer_ctrl;
  import tick_timer_ctrl_pkg::*;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             clear;
  logic             periodic;
  logic [CNT_W-1:0] load_val;
  logic             tick_o;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             done_pulse;
  logic             expired;
  logic             load_err;

  int total = 0;
  int bad   = 0;

  tick_timer_ctrl #(
    .DIV   (DIV_SIM),
    .PRE_W (3),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .periodic   (periodic),
    .load_val   (load_val),
    .tick_o     (tick_o),
    .remaining  (remaining),
    .busy       (busy),
    .done_pulse (done_pulse),
    .expired    (expired),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic b, input logic e, input logic d);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".expired"}, 32'(expired), 32'(e));
    chk({tag, ".done"}, 32'(done_pulse), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    periodic = 1'b0; load_val = '0;
    step(); step();
    chk("rst.remaining", 32'(remaining), 0);
    chk("rst.tick", 32'(tick_o), 0);
    chk("rst.load_err", 32'(load_err), 0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // One-shot from 3: ticks after edges 3,7,11; done on edge 12.
    start = 1'b1; load_val = 8'd3; periodic = 1'b0;
    step();
    start = 1'b0;
    chk("os.load", 32'(remaining), 3);
    chk("os.busy0", 32'(busy), 1);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("os.tick%0d", k), 32'(tick_o), 32'(k == 3 || k == 7 || k == 11));
      chk($sformatf("os.rem%0d", k), 32'(remaining),
          (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0);
      check_flags($sformatf("os%0d", k), k < 12, k >= 12, k == 12);
    end

    // Periodic from 2: done on edges 8 and 16, remaining alternates 2/1.
    start = 1'b1; load_val = 8'd2; periodic = 1'b1;
    step();
    start = 1'b0;
    check_flags("per0", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("per.tick%0d", k), 32'(tick_o), 32'((k % 4) == 3));
      chk($sformatf("per.rem%0d", k), 32'(remaining), ((k / 4) % 2 == 1) ? 1 : 2);
      check_flags($sformatf("per%0d", k), 1'b1, 1'b0, k == 8 || k == 16);
    end

    // clear and start together: clear wins.
    clear = 1'b1; start = 1'b1; load_val = 8'd7;
    step();
    clear = 1'b0; start = 1'b0;
    chk("clr.rem", 32'(remaining), 0);
    check_flags("clr", 1'b0, 1'b0, 1'b0);

    // Pause at prescaler=2 with remaining=4, hold, resume.
    start = 1'b1; load_val = 8'd5; periodic = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pz.tick3", 32'(tick_o), 1);
    step();
    chk("pz.rem4", 32'(remaining), 4);
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pz.enter.rem", 32'(remaining), 4);
    check_flags("pz.enter", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("pz.hold.tick%0d", k), 32'(tick_o), 0);
      chk($sformatf("pz.hold.rem%0d", k), 32'(remaining), 4);
      chk($sformatf("pz.hold.busy%0d", k), 32'(busy), 1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs.tick0", 32'(tick_o), 0);
    chk("rs.rem0", 32'(remaining), 4);
    step();
    chk("rs.tick1", 32'(tick_o), 1);
    step();
    chk("rs.rem2", 32'(remaining), 3);
    chk("rs.tick2", 32'(tick_o), 0);

    // Restart on the same cycle as a tick: reload, no decrement.
    step(); step(); step();
    chk("rt.tick", 32'(tick_o), 1);
    chk("rt.rem_pre", 32'(remaining), 3);
    start = 1'b1; load_val = 8'd9;
    step();
    start = 1'b0;
    chk("rt.rem", 32'(remaining), 9);
    chk("rt.done", 32'(done_pulse), 0);
    chk("rt.tick_after", 32'(tick_o), 0);
    step();
    chk("rt.rem_hold", 32'(remaining), 9);

    // Stop on the final one-shot tick: still completes to DONE.
    start = 1'b1; load_val = 8'd1; periodic = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("sf.tick", 32'(tick_o), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sf.rem", 32'(remaining), 0);
    check_flags("sf", 1'b0, 1'b1, 1'b1);
    step();
    check_flags("sf.after", 1'b0, 1'b1, 1'b0);

    // Zero load is rejected with a one-cycle load_err.
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1; load_val = 8'd0;
    step();
    start = 1'b0;
    chk("rej.err", 32'(load_err), 1);
    check_flags("rej", 1'b0, 1'b0, 1'b0);
    step();
    chk("rej.err_clr", 32'(load_err), 0);
    chk("rej.rem", 32'(remaining), 0);

    // Reset while a tick is pending at remaining=3.
    start = 1'b1; load_val = 8'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("mr.tick", 32'(tick_o), 1);
    chk("mr.rem_pre", 32'(remaining), 3);
    rst_n = 1'b0;
    step();
    chk("mr.rem", 32'(remaining), 0);
    chk("mr.tick0", 32'(tick_o), 0);
    chk("mr.load_err", 32'(load_err), 0);
    check_flags("mr", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_flags("mr.after", 1'b0, 1'b0, 1'b0);
    chk("mr.rem_after", 32'(remaining), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_timer_ctrl.md
Name: tick_timer_ctrl

Overview:
- Countdown-timer controller that owns a free-running prescaler. It sequences the prescaler into a one-cycle tick enable (nominally 1 Hz from a 100 MHz clock) and counts ticks down from a loaded value.
- Supports start, pause/resume, clear, and one-shot or periodic modes.
- Replaces toggled derived clocks: downstream logic (display, alarm, FSMs) stays on clk and qualifies on tick_o / done_pulse.

Parameters:
- DIV, 100000000, prescaler period in clk cycles per tick (must be ≥ 2).
- PRE_W, 27, prescaler counter width (must satisfy 2^PRE_W ≥ DIV).
- CNT_W, 8, countdown width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  level-sampled. In IDLE/DONE: load and run. In PAUSE: resume. In RUN: restart.
- stop  input  1  in RUN: pause. Ignored in other states.
- clear  input  1  return to IDLE from any state.
- periodic  input  1  mode; sampled and latched at load.
- load_val  input  CNT_W  countdown start value; latched at load.
- tick_o  output  1  one-cycle pulse on each prescaler wrap while in RUN.
- remaining  output  CNT_W  current countdown value.
- busy  output  1  high in RUN or PAUSE.
- done_pulse  output  1  one-cycle pulse when the count reaches 0.
- expired  output  1  high in DONE.
- load_err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- All regs update only on the rising edge of clk. rst_n=0 forces:
  - state = IDLE
  - prescaler = 0, remaining = 0, reload reg = 0, mode reg = 0
  - all pulses and flags = 0
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- Command priority in the same cycle: clear > start > stop.
- clear: next state IDLE; prescaler = 0; remaining = 0; no done_pulse.
- start in IDLE or DONE:
  - If load_val ≠ 0: next state RUN; remaining = load_val; latch load_val into the reload reg and periodic into the mode reg; prescaler = 0.
  - If load_val = 0: state unchanged; load_err pulses for 1 cycle.
- start in RUN: same as the load case (restart). The latched mode is re-latched.
- start in PAUSE: resume to RUN. remaining and prescaler are kept; nothing is re-latched.
- stop in RUN: next state PAUSE; prescaler and remaining are frozen.
- Prescaler:
  - Counts only in RUN; holds in PAUSE; equals 0 in IDLE and DONE.
  - Counts 0..DIV-1 and wraps to 0.
  - tick_o is combinational and equals (state==RUN && prescaler==DIV-1).
  - First tick occurs DIV cycles after the RUN entry edge.
- On tick in RUN:
  - If remaining > 1: remaining decrements by 1.
  - If remaining == 1: done_pulse is registered high for the next cycle.
    - One-shot mode: remaining = 0, next state DONE.
    - Periodic mode: remaining = reload value, stay in RUN, no gap in ticks.
- Tick and stop in the same cycle: the tick is consumed (decrement or done processing happens), then the next state is PAUSE.
- Tick and start (restart) in the same cycle: start wins; no decrement and no done_pulse.
- Flags:
  - expired is high exactly while in DONE and stays high until start or clear.
  - busy = (state==RUN || state==PAUSE).
- No arithmetic wrap: remaining never decrements below 0.
- Reset mid-count aborts immediately. No done_pulse is emitted.

Decomposition:
- Shared package holds:
  - state enum (TT_IDLE, TT_RUN, TT_PAUSE, TT_DONE)
  - DIV_1HZ = 100000000
  - DIV_SIM = 4 (for simulation)
- Natural sub-module: tick_prescaler (clk, rst_n, en, clr -> tick).
  - A counter with synchronous clear and enable.
  - Instantiated once; tick_timer_ctrl drives en = (state==RUN) and clr on load, clear, IDLE and DONE.

Test Plan (DIV=4, CNT_W=8):
- One-shot countdown: reset, then start with load_val=3, periodic=0.
  - tick_o at cycles 4, 8, 12 after RUN entry.
  - remaining goes 3→2→1→0.
  - done_pulse one cycle after the 3rd tick; expired=1; busy=0.
- Periodic reload: start with load_val=2, periodic=1; run 20 cycles.
  - done_pulse every 8 cycles.
  - remaining cycles 2→1→2…
  - Never enters DONE; tick_o is continuous.
- Pause and resume: load_val=5. Assert stop at prescaler=2 with remaining=4. Hold in PAUSE for 10 cycles, then start.
  - remaining stays 4 and no tick_o during PAUSE.
  - After resume, the next tick arrives 2 cycles later.
- Simultaneous events:
  - clear+start in the same cycle → IDLE.
  - start coincident with a tick → remaining = load_val, no decrement.
  - stop coincident with the final tick → done_pulse, then state DONE.
- Rejects and reset:
  - start with load_val=0 → load_err for 1 cycle, state stays IDLE.
  - rst_n=0 mid-RUN at remaining=3 → next cycle all outputs 0, no done_pulse.
